// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings and lane helpers for the wait-state MEM stage
//
// Purpose: access-size encodings, the MEM FSM state type and the byte-lane
// helpers used by mem_stage_ws. All lane helpers assume a 32-bit
// little-endian word where lane n holds bits [8n+7:8n].
// Ports: none (package).

package mem_pkg;

  localparam int unsigned WORD_W = 32;

  // Access size encodings; 2'b11 is reserved and handled like a word.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Byte-enable mask for a store of the given size at the given lane.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << lane;
      SZ_HALF: lane_mask = 4'b0011 << lane;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // Replicate the right-aligned store value so every candidate lane carries
  // the right bytes; lane_mask then picks which of them land.
  function automatic logic [WORD_W-1:0] store_align(input logic [WORD_W-1:0] wdata,
                                                    input logic [1:0] size);
    case (size)
      SZ_BYTE: store_align = {4{wdata[7:0]}};
      SZ_HALF: store_align = {2{wdata[15:0]}};
      default: store_align = wdata;
    endcase
  endfunction

  // Half needs an even lane, word needs lane 0; bytes are always aligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = lane[0];
      default: misaligned = (lane != 2'b00);
    endcase
  endfunction

  // Pull the addressed byte/half down to bit 0 and extend it.
  function automatic logic [WORD_W-1:0] load_extend(input logic [WORD_W-1:0] word,
                                                    input logic [1:0] size,
                                                    input logic [1:0] lane,
                                                    input logic sgn);
    logic [WORD_W-1:0] sh;
    sh = word >> {lane, 3'b000};
    case (size)
      SZ_BYTE: load_extend = {{24{sgn & sh[7]}}, sh[7:0]};
      SZ_HALF: load_extend = {{16{sgn & sh[15]}}, sh[15:0]};
      default: load_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_be.sv
// rtl/data_memory_be.sv - word-organised data RAM with byte-enable write and async read
//
// Purpose: DEPTH x 32 storage. Contents are never reset.
// Ports:
//   clk_i    - write clock
//   be_i     - per-lane write enables (all zero = no write)
//   addr_i   - word index
//   wdata_i  - lane-aligned write data
//   rdata_o  - combinational read of the addressed word (pre-write value)

module data_memory_be #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (be_i[b]) begin
        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage_ws.sv
// rtl/mem_stage_ws.sv - MEM stage with sized loads/stores, wait states and MEM/WB register
//
// Purpose: executes the memory access of the instruction in the EX/MEM latch,
// stalling the pipeline for WAIT_STATES cycles per aligned access, flagging
// misaligned accesses, and registering the result into MEM/WB.
// Ports:
//   clk, reset                     - clock, synchronous active-high reset
//   valid_in                       - EX/MEM holds a live instruction
//   Branch, MemRead, MemWrite      - EX/MEM control
//   MemSize, MemSigned             - access size and load extension
//   control_wb_in                  - {RegWrite, MemtoReg}
//   Address, Write_data            - byte address, right-aligned store data
//   Write_reg_in, zero             - destination register, ALU zero flag
//   PCSrc                          - branch taken (combinational)
//   stall                          - hold upstream stages (combinational)
//   misalign                       - misaligned access presented (combinational)
//   mem_valid, mem_control_wb,
//   Read_data, mem_ALU_result,
//   mem_Write_reg                  - MEM/WB register outputs

module mem_stage_ws
  import mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2,
  parameter int REG_W       = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic              Branch,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        MemSize,
  input  logic              MemSigned,
  input  logic [1:0]        control_wb_in,
  input  logic [DATA_W-1:0] Address,
  input  logic [DATA_W-1:0] Write_data,
  input  logic [REG_W-1:0]  Write_reg_in,
  input  logic              zero,
  output logic              PCSrc,
  output logic              stall,
  output logic              mem_valid,
  output logic [1:0]        mem_control_wb,
  output logic [DATA_W-1:0] Read_data,
  output logic [DATA_W-1:0] mem_ALU_result,
  output logic [REG_W-1:0]  mem_Write_reg,
  output logic              misalign
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("mem_stage_ws: DATA_W must be 32");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("mem_stage_ws: DEPTH must be a power of 2");
  end
  if ((WAIT_STATES < 0) || (WAIT_STATES > 15)) begin : g_bad_ws
    $error("mem_stage_ws: WAIT_STATES must be 0..15");
  end

  // Address bits above the word index are ignored, so accesses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^Address[DATA_W-1:AW+2];

  logic [1:0]    lane;
  logic          mem_op;
  logic          mis_addr;
  logic          mis;
  logic          acc;
  logic          access_now;
  logic [3:0]    be;
  logic [31:0]   wdata_lanes;
  logic [31:0]   rdata_word;
  logic [31:0]   load_data;

  state_e        state_q;
  logic [3:0]    cnt_q;

  logic              valid_q,  valid_d;
  logic [1:0]        ctl_q,    ctl_d;
  logic [DATA_W-1:0] rdata_q,  rdata_d;
  logic [DATA_W-1:0] alu_q,    alu_d;
  logic [REG_W-1:0]  wreg_q,   wreg_d;

  assign lane     = Address[1:0];
  assign mem_op   = valid_in & (MemRead | MemWrite);
  assign mis_addr = misaligned(MemSize, lane);
  assign mis      = mem_op & mis_addr;
  assign acc      = mem_op & ~mis_addr;

  // The access cycle: in IDLE when there are no wait states, otherwise the
  // last WAIT cycle. Upstream holds its inputs across the stall, so acc is
  // still describing the same instruction here.
  assign access_now = acc & (((state_q == ST_IDLE) && (WS == 4'd0)) ||
                             ((state_q == ST_WAIT) && (cnt_q == 4'd1)));

  assign stall = ~reset & (((state_q == ST_IDLE) && acc && (WS != 4'd0)) ||
                           ((state_q == ST_WAIT) && (cnt_q > 4'd1)));

  assign misalign = ~reset & mis;
  assign PCSrc    = Branch & zero & valid_in;

  assign be          = (access_now && MemWrite && !reset) ? lane_mask(MemSize, lane) : 4'b0000;
  assign wdata_lanes = store_align(Write_data, MemSize);

  data_memory_be #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_dmem (
    .clk_i   (clk),
    .be_i    (be),
    .addr_i  (Address[AW+1:2]),
    .wdata_i (wdata_lanes),
    .rdata_o (rdata_word)
  );

  // Async read sees the pre-write word even when a store commits this cycle.
  assign load_data = load_extend(rdata_word, MemSize, lane, MemSigned);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else if (state_q == ST_IDLE) begin
      if (acc && (WS != 4'd0)) begin
        state_q <= ST_WAIT;
        cnt_q   <= WS;
      end
    end else begin
      cnt_q <= cnt_q - 4'd1;
      if (cnt_q <= 4'd1) begin
        state_q <= ST_IDLE;
      end
    end
  end

  // Stalled cycles push a bubble; data fields are held. A misaligned
  // instruction still advances but with its writeback controls cleared.
  always_comb begin
    valid_d = valid_q;
    ctl_d   = ctl_q;
    rdata_d = rdata_q;
    alu_d   = alu_q;
    wreg_d  = wreg_q;
    if (stall) begin
      valid_d = 1'b0;
      ctl_d   = 2'b00;
    end else begin
      valid_d = valid_in;
      ctl_d   = (valid_in && !mis) ? control_wb_in : 2'b00;
      rdata_d = load_data;
      alu_d   = Address;
      wreg_d  = Write_reg_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctl_q   <= 2'b00;
      rdata_q <= '0;
      alu_q   <= '0;
      wreg_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctl_q   <= ctl_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      wreg_q  <= wreg_d;
    end
  end

  assign mem_valid      = valid_q;
  assign mem_control_wb = ctl_q;
  assign Read_data      = rdata_q;
  assign mem_ALU_result = alu_q;
  assign mem_Write_reg  = wreg_q;

endmodule

// File: tb/tb_mem_stage_ws.sv
// tb/tb_mem_stage_ws.sv - self-checking bench for mem_stage_ws (2 and 0 wait states)

module tb_mem_stage_ws;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in, valid0;
  logic        Branch, MemRead, MemWrite, MemSigned, zero;
  logic [1:0]  MemSize, control_wb_in;
  logic [31:0] Address, Write_data;
  logic [4:0]  Write_reg_in;

  logic        PCSrc, stall, mem_valid, misalign;
  logic [1:0]  mem_control_wb;
  logic [31:0] Read_data, mem_ALU_result;
  logic [4:0]  mem_Write_reg;

  logic        PCSrc0, stall0, mem_valid0, misalign0;
  logic [1:0]  mem_control_wb0;
  logic [31:0] Read_data0, mem_ALU_result0;
  logic [4:0]  mem_Write_reg0;

  always #5 clk = ~clk;

  mem_stage_ws #(.DATA_W(32), .DEPTH(256), .WAIT_STATES(2), .REG_W(5)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .Branch(Branch),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize), .MemSigned(MemSigned),
    .control_wb_in(control_wb_in), .Address(Address), .Write_data(Write_data),
    .Write_reg_in(Write_reg_in), .zero(zero), .PCSrc(PCSrc), .stall(stall),
    .mem_valid(mem_valid), .mem_control_wb(mem_control_wb), .Read_data(Read_data),
    .mem_ALU_result(mem_ALU_result), .mem_Write_reg(mem_Write_reg), .misalign(misalign)
  );

  mem_stage_ws #(.DATA_W(32), .DEPTH(16), .WAIT_STATES(0), .REG_W(5)) dut0 (
    .clk(clk), .reset(reset), .valid_in(valid0), .Branch(Branch),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize), .MemSigned(MemSigned),
    .control_wb_in(control_wb_in), .Address(Address), .Write_data(Write_data),
    .Write_reg_in(Write_reg_in), .zero(zero), .PCSrc(PCSrc0), .stall(stall0),
    .mem_valid(mem_valid0), .mem_control_wb(mem_control_wb0), .Read_data(Read_data0),
    .mem_ALU_result(mem_ALU_result0), .mem_Write_reg(mem_Write_reg0), .misalign(misalign0)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference memory: flat byte array, little-endian, wraps at 1 KiB.
  logic [7:0] model_mem [1024];

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic model_mis(input logic [1:0] size, input logic [31:0] addr);
    return (int'(addr % 32'd4) % nbytes(size)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size,
                                             input logic sgn);
    int n;
    int base;
    logic [63:0] v;
    n    = nbytes(size);
    base = int'(addr % 32'd1024);
    v    = 64'd0;
    for (int i = 0; i < n; i++)
      v = v | (64'(model_mem[(base + i) % 1024]) << (8 * i));
    if (sgn && n < 4 && v[8*n-1])
      v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd);
    int n;
    int base;
    n    = nbytes(size);
    base = int'(addr % 32'd1024);
    for (int i = 0; i < n; i++)
      model_mem[(base + i) % 1024] = 8'(wd >> (8 * i));
  endtask

  // Results of the last run_op.
  logic        r_done, r_mis, r_valid;
  int          r_stalls, r_edges;
  logic [1:0]  r_ctl;
  logic [31:0] r_rd, r_alu, r_exp_rd;
  logic [4:0]  r_wreg;

  // Present one instruction to DUT `sel` (0: 2 wait states, 1: none) and
  // hold it until the cycle with stall low has closed.
  task automatic run_op(input int sel, input logic rd, input logic wr, input logic [1:0] size,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] ctl, input logic [4:0] wreg);
    logic done;
    int   cyc;
    valid_in = (sel == 0); valid0 = (sel == 1);
    MemRead = rd; MemWrite = wr; MemSize = size; MemSigned = sgn;
    Address = addr; Write_data = wd; control_wb_in = ctl; Write_reg_in = wreg;
    r_exp_rd = model_load(addr, size, sgn);
    r_stalls = 0; r_mis = 1'b0; done = 1'b0; cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      if (cyc == 0) r_mis = (sel == 1) ? misalign0 : misalign;
      if ((sel == 1) ? stall0 : stall) begin
        r_stalls++;
        if (cyc > 0) chk("bubble mem_valid", {31'd0, (sel == 1) ? mem_valid0 : mem_valid}, 32'd0);
      end else begin
        done = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    r_done  = done;
    r_edges = cyc;
    r_valid = (sel == 1) ? mem_valid0      : mem_valid;
    r_ctl   = (sel == 1) ? mem_control_wb0 : mem_control_wb;
    r_rd    = (sel == 1) ? Read_data0      : Read_data;
    r_alu   = (sel == 1) ? mem_ALU_result0 : mem_ALU_result;
    r_wreg  = (sel == 1) ? mem_Write_reg0  : mem_Write_reg;
    if (sel == 0 && wr && !model_mis(size, addr)) model_store(addr, size, wd);
  endtask

  task automatic go_idle();
    valid_in = 1'b0; valid0 = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    int          sel;
    logic        rd, wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr, wdata;
    logic [1:0]  ctl;
    logic        chk_rd;
    logic [31:0] exp_rd;
    int          exp_st;
    logic        exp_mis;
    logic [1:0]  exp_ctl;
  } vec_t;

  function automatic vec_t mk(input int sel, input logic rd, input logic wr, input logic [1:0] size,
                              input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [1:0] ctl, input logic chk_rd, input logic [31:0] exp_rd,
                              input int exp_st, input logic exp_mis, input logic [1:0] exp_ctl);
    vec_t v;
    v.sel = sel; v.rd = rd; v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr;
    v.wdata = wdata; v.ctl = ctl; v.chk_rd = chk_rd; v.exp_rd = exp_rd;
    v.exp_st = exp_st; v.exp_mis = exp_mis; v.exp_ctl = exp_ctl;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t v;
    logic [31:0] a, wd;
    logic rd, wr, m;
    logic [1:0] sz, ctl;
    int st;

    //         sel rd wr size  sgn addr          wdata         ctl  chk exp_rd        st mis ectl
    tbl.push_back(mk(0, 0, 1, 2'b10, 0, 32'h10,       32'hDEADBEEF, 2'b00, 0, 32'h0,        2, 0, 2'b00));
    tbl.push_back(mk(0, 1, 0, 2'b10, 0, 32'h10,       32'h0,        2'b11, 1, 32'hDEADBEEF, 2, 0, 2'b11));
    tbl.push_back(mk(0, 0, 1, 2'b10, 0, 32'h10,       32'h0,        2'b00, 0, 32'h0,        2, 0, 2'b00));
    tbl.push_back(mk(0, 0, 1, 2'b00, 0, 32'h13,       32'h80,       2'b00, 0, 32'h0,        2, 0, 2'b00));
    tbl.push_back(mk(0, 1, 0, 2'b00, 1, 32'h13,       32'h0,        2'b11, 1, 32'hFFFFFF80, 2, 0, 2'b11));
    tbl.push_back(mk(0, 1, 0, 2'b00, 0, 32'h13,       32'h0,        2'b11, 1, 32'h00000080, 2, 0, 2'b11));
    tbl.push_back(mk(0, 1, 0, 2'b10, 0, 32'h10,       32'h0,        2'b11, 1, 32'h80000000, 2, 0, 2'b11));
    tbl.push_back(mk(0, 1, 0, 2'b01, 1, 32'h11,       32'h0,        2'b11, 0, 32'h0,        0, 1, 2'b00));
    tbl.push_back(mk(0, 0, 1, 2'b10, 0, 32'h12,       32'hFFFFFFFF, 2'b10, 0, 32'h0,        0, 1, 2'b00));
    tbl.push_back(mk(0, 1, 0, 2'b10, 0, 32'h10,       32'h0,        2'b11, 1, 32'h80000000, 2, 0, 2'b11));
    tbl.push_back(mk(0, 1, 0, 2'b01, 1, 32'h12,       32'h0,        2'b11, 1, 32'hFFFF8000, 2, 0, 2'b11));
    tbl.push_back(mk(0, 1, 0, 2'b01, 0, 32'h12,       32'h0,        2'b11, 1, 32'h00008000, 2, 0, 2'b11));
    tbl.push_back(mk(0, 0, 1, 2'b01, 0, 32'h12,       32'hFFFF1234, 2'b00, 0, 32'h0,        2, 0, 2'b00));
    tbl.push_back(mk(0, 1, 0, 2'b10, 0, 32'h10,       32'h0,        2'b11, 1, 32'h12340000, 2, 0, 2'b11));
    tbl.push_back(mk(0, 1, 1, 2'b10, 0, 32'h10,       32'hAAAA5555, 2'b11, 1, 32'h12340000, 2, 0, 2'b11));
    tbl.push_back(mk(0, 1, 0, 2'b11, 0, 32'h10,       32'h0,        2'b11, 1, 32'hAAAA5555, 2, 0, 2'b11));
    tbl.push_back(mk(0, 1, 0, 2'b10, 0, 32'h410,      32'h0,        2'b11, 1, 32'hAAAA5555, 2, 0, 2'b11));
    tbl.push_back(mk(0, 1, 0, 2'b10, 0, 32'hFFFFFC10, 32'h0,        2'b11, 1, 32'hAAAA5555, 2, 0, 2'b11));
    tbl.push_back(mk(0, 0, 1, 2'b00, 0, 32'h10,       32'h1234567F, 2'b00, 0, 32'h0,        2, 0, 2'b00));
    tbl.push_back(mk(0, 1, 0, 2'b01, 1, 32'h10,       32'h0,        2'b11, 1, 32'h0000557F, 2, 0, 2'b11));
    tbl.push_back(mk(0, 1, 0, 2'b01, 1, 32'h12,       32'h0,        2'b11, 1, 32'hFFFFAAAA, 2, 0, 2'b11));
    tbl.push_back(mk(0, 0, 0, 2'b10, 0, 32'h12345677, 32'h0,        2'b10, 0, 32'h0,        0, 0, 2'b10));
    tbl.push_back(mk(1, 0, 1, 2'b10, 0, 32'h4,        32'h11111111, 2'b00, 0, 32'h0,        0, 0, 2'b00));
    tbl.push_back(mk(1, 1, 0, 2'b10, 0, 32'h4,        32'h0,        2'b11, 1, 32'h11111111, 0, 0, 2'b11));
    tbl.push_back(mk(1, 0, 1, 2'b10, 0, 32'h4,        32'h5A5A1234, 2'b00, 0, 32'h0,        0, 0, 2'b00));
    tbl.push_back(mk(1, 1, 0, 2'b10, 0, 32'h4,        32'h0,        2'b11, 1, 32'h5A5A1234, 0, 0, 2'b11));

    for (int i = 0; i < 1024; i++) model_mem[i] = 8'h00;

    // Reset: combinational outputs low even with a misaligned / aligned access presented.
    reset = 1'b1; valid_in = 1'b1; valid0 = 1'b0; Branch = 1'b0; zero = 1'b0;
    MemRead = 1'b1; MemWrite = 1'b0; MemSize = 2'b01; MemSigned = 1'b0;
    control_wb_in = 2'b11; Address = 32'h11; Write_data = 32'h0; Write_reg_in = 5'd7;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset misalign", {31'd0, misalign}, 32'd0);
    chk("reset mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("reset mem_control_wb", {30'd0, mem_control_wb}, 32'd0);
    chk("reset Read_data", Read_data, 32'd0);
    chk("reset mem_ALU_result", mem_ALU_result, 32'd0);
    chk("reset mem_Write_reg", {27'd0, mem_Write_reg}, 32'd0);
    MemSize = 2'b10; Address = 32'h10;
    #1;
    chk("reset stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    go_idle();

    foreach (tbl[i]) begin
      v = tbl[i];
      run_op(v.sel, v.rd, v.wr, v.size, v.sgn, v.addr, v.wdata, v.ctl, 5'(i));
      chk($sformatf("v%0d done", i), {31'd0, r_done}, 32'd1);
      chk($sformatf("v%0d stalls", i), 32'(r_stalls), 32'(v.exp_st));
      chk($sformatf("v%0d latency", i), 32'(r_edges), 32'(v.exp_st + 1));
      chk($sformatf("v%0d misalign", i), {31'd0, r_mis}, {31'd0, v.exp_mis});
      chk($sformatf("v%0d mem_valid", i), {31'd0, r_valid}, 32'd1);
      chk($sformatf("v%0d ctl", i), {30'd0, r_ctl}, {30'd0, v.exp_ctl});
      chk($sformatf("v%0d alu", i), r_alu, v.addr);
      chk($sformatf("v%0d wreg", i), {27'd0, r_wreg}, 32'(i % 32));
      if (v.chk_rd) chk($sformatf("v%0d Read_data", i), r_rd, v.exp_rd);
    end
    go_idle();

    // PCSrc during a stall, then with valid_in low.
    Branch = 1'b1; zero = 1'b1;
    valid_in = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; MemSize = 2'b10;
    Address = 32'h30; Write_data = 32'h0;
    @(negedge clk);
    chk("pcsrc stall0 stall", {31'd0, stall}, 32'd1);
    chk("pcsrc stall0 PCSrc", {31'd0, PCSrc}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pcsrc stall1 PCSrc", {31'd0, PCSrc}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pcsrc access stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    model_store(32'h30, 2'b10, 32'h0);
    valid_in = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
    chk("pcsrc invalid", {31'd0, PCSrc}, 32'd0);
    @(posedge clk); #1;
    Branch = 1'b0; zero = 1'b0;

    // Reset on the first WAIT cycle of a store aborts it.
    run_op(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, 2'b00, 5'd3);
    chk("prestore done", {31'd0, r_done}, 32'd1);
    Write_data = 32'h12345678;
    @(negedge clk);
    chk("abort present stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort reset stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; valid_in = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
    chk("abort after stall", {31'd0, stall}, 32'd0);
    chk("abort mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("abort ctl", {30'd0, mem_control_wb}, 32'd0);
    chk("abort Read_data", Read_data, 32'd0);
    chk("abort alu", mem_ALU_result, 32'd0);
    chk("abort wreg", {27'd0, mem_Write_reg}, 32'd0);
    @(posedge clk); #1;
    run_op(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 2'b11, 5'd4);
    chk("abort lw Read_data", r_rd, 32'hCAFEF00D);
    chk("abort lw stalls", 32'(r_stalls), 32'd2);
    go_idle();

    // Random traffic on words 0..15 (with random upper address bits).
    for (int w = 0; w < 16; w++)
      run_op(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'(w * 4), 32'h0, 2'b00, 5'd0);
    for (int k = 0; k < 150; k++) begin
      a = $urandom;
      a[9:6] = 4'b0000;
      wd  = $urandom;
      sz  = 2'($urandom_range(0, 3));
      ctl = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: begin rd = 1'b1; wr = 1'b0; end
        1: begin rd = 1'b0; wr = 1'b1; end
        2: begin rd = 1'b1; wr = 1'b1; end
        default: begin rd = 1'b0; wr = 1'b0; end
      endcase
      m  = (rd | wr) & model_mis(sz, a);
      st = ((rd | wr) && !m) ? 2 : 0;
      run_op(0, rd, wr, sz, 1'($urandom_range(0, 1)), a, wd, ctl, 5'(k));
      chk($sformatf("r%0d stalls", k), 32'(r_stalls), 32'(st));
      chk($sformatf("r%0d latency", k), 32'(r_edges), 32'(st + 1));
      chk($sformatf("r%0d misalign", k), {31'd0, r_mis}, {31'd0, m});
      chk($sformatf("r%0d mem_valid", k), {31'd0, r_valid}, 32'd1);
      chk($sformatf("r%0d ctl", k), {30'd0, r_ctl}, m ? 32'd0 : {30'd0, ctl});
      chk($sformatf("r%0d alu", k), r_alu, a);
      if (rd && !m) chk($sformatf("r%0d Read_data", k), r_rd, r_exp_rd);
    end
    go_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_ws.md
# mem_stage_ws

Parametrised MEM stage: successor to the fixed single-cycle memory stage, sitting between the EX/MEM latch and the WB stage. Adds byte, half and word loads/stores with sign/zero extension, a configurable wait-state memory with a stall handshake back to the pipeline, and misalignment detection. The MEM/WB pipeline register is kept inside the block.

## Interface
**Parameters**
- `DATA_W`, 32: datapath width. Supported value is 32 only; other values are a lint error.
- `DEPTH`, 256: data memory depth in words. Must be a power of 2.
- `WAIT_STATES`, 2: extra cycles per memory access. Range 0–15; 0 gives single-cycle behaviour.
- `REG_W`, 5: destination register index width.

**Ports** (one clock; reset is synchronous and active-high)
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `valid_in` in 1: EX/MEM latch holds a live instruction.
- `Branch`, `MemRead`, `MemWrite` in 1 each: control from the EX/MEM latch.
- `MemSize` in 2: access size. 00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word).
- `MemSigned` in 1: 1 = sign-extend loads, 0 = zero-extend.
- `control_wb_in` in 2: {RegWrite, MemtoReg}.
- `Address` in DATA_W: ALU result, used as the byte address.
- `Write_data` in DATA_W: store value, right-aligned.
- `Write_reg_in` in REG_W: destination register.
- `zero` in 1: ALU zero flag.
- `PCSrc` out 1: branch taken.
- `stall` out 1: freezes PC, IF/ID and ID/EX, and the EX/MEM latch.
- `mem_valid` out 1: MEM/WB register holds a live instruction.
- `mem_control_wb` out 2: WB control.
- `Read_data` out DATA_W: extended load data.
- `mem_ALU_result` out DATA_W: Address passed through.
- `mem_Write_reg` out REG_W: destination register passed through.
- `misalign` out 1: one-cycle flag for a misaligned access.

## Operation
- `PCSrc` = `Branch & zero & valid_in`. Combinational and independent of stall.
- An access is `acc = valid_in & (MemRead | MemWrite) & ~mis`.
- Misalignment `mis`:
  - half access with Address[0]=1;
  - word access with Address[1:0]≠0.
- Word index is Address[log2(DEPTH)+1:2]. Upper address bits are ignored, so out-of-range addresses wrap.
- Byte lanes are little-endian; lane = Address[1:0].
- Stores write only the selected lanes:
  - byte: lane ← Write_data[7:0];
  - half: lanes {A1,A1+1} ← Write_data[15:0];
  - word: all 4 lanes.
- Loads select the addressed byte or half, then extend per `MemSigned`.
- If MemRead and MemWrite are both set, the block performs a write and `Read_data` is the pre-write word contents, extracted and extended.
- FSM states: IDLE, WAIT.
  - IDLE with acc and WAIT_STATES>0: load counter with WAIT_STATES, go to WAIT, assert `stall`.
  - WAIT: decrement counter each cycle. `stall`=1 while counter>1. The cycle with counter==1 is the access cycle: stall=0, the write commits and the MEM/WB register loads at its closing edge, then return to IDLE.
  - WAIT_STATES=0: the access completes in IDLE the same cycle, as the old stage did.
- While `stall`=1, upstream holds all EX/MEM inputs constant. The MEM/WB register loads a bubble: mem_valid=0, mem_control_wb=0, other fields don't-care but held.
- Misaligned instruction:
  - no memory write;
  - `misalign`=1 for exactly the cycle it is presented;
  - MEM/WB loads with mem_valid=1 and mem_control_wb=0;
  - no stall.
- Non-memory valid instruction: passes to MEM/WB in 1 cycle, no stall.

## Timing
- Reset drives: state IDLE, counter 0, mem_valid 0, mem_control_wb 0, Read_data 0, mem_ALU_result 0, mem_Write_reg 0. Memory contents are not reset.
- Combinational outputs under reset: stall=0, misalign=0.
- Latency from a presented instruction to MEM/WB output is WAIT_STATES+1 rising edges for memory ops, 1 for all others.
- Stall is asserted for exactly WAIT_STATES cycles per access.
- Reset during WAIT: FSM aborts, no write commits, stall=0 in the next cycle.
- Back-to-back accesses: a new access may be presented in the cycle after the access cycle. It gets its full wait period; there is no overlap.
- Memory read is asynchronous from the array. The write is synchronous on `clk`.

## Structure
- Package `mem_pkg`:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - FSM state enum;
  - function `lane_mask(size, addr[1:0])`;
  - function `load_extend(word, size, lane, signed)`.
- Sub-module `data_memory_be`: DEPTH×32 array, 4-bit byte-enable write, asynchronous read.
- FSM, counter, misalignment logic and the MEM/WB register live in `mem_stage_ws`.

## Test plan
- WAIT_STATES=2, store word 0xDEADBEEF to 0x10 → stall=1 for 2 cycles. Then load word from 0x10 → Read_data=0xDEADBEEF, with mem_valid=1 exactly 3 edges after presentation.
- Store byte 0x80 to 0x13 over 0x00000000, then `lb` 0x13 → 0xFFFFFF80; `lbu` 0x13 → 0x00000080; `lw` 0x10 → 0x80000000.
- `lh` at 0x11 → misalign=1 for one cycle, no stall, mem_control_wb=0, memory unchanged.
- Reset asserted on the first WAIT cycle of a store of 0x12345678 to 0x20 → subsequent `lw` 0x20 returns the prior value; all outputs 0 after reset.
- Branch=1, zero=1, valid_in=1 during a stall → PCSrc=1. With valid_in=0 → PCSrc=0.
- WAIT_STATES=0 build: 3 back-to-back `lw`/`sw`/`lw` at 0x4 → no stall, 1-cycle latency each, and the second load sees the stored data.
